rf68000_ring_gbl_responder: RTL and testbench

- Ring endpoint for the global node (default id 62): the responder side of the NIC request/response protocol.
- Removes request packets addressed to it from the request ring, buffers them in a small FIFO, and runs each one as a bus-master cycle on the global memory/IO bus.
- Returns ACK/AACK/ERR/VPA/RETRY response packets on the response ring.
- Sits between the request/response rings and the global DRAM/ROM/IO interconnect.

---
 rtl/nic_pkg.sv | 53 +++++
 rtl/rf68000_ring_req_fifo.sv | 53 +++++
 rtl/rf68000_ring_gbl_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_rf68000_ring_gbl_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nic_pkg.sv
// Shared NIC ring packet format, packet type codes and node ids.
// Also holds the bus FSM state type used by the global responder.
package nic_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [5:0] GBL_NODE_ID = 6'd62;
    localparam logic [5:0] BCAST_ID    = 6'd63;
    localparam logic [5:0] EMPTY_ID    = 6'd0;

    typedef enum logic [4:0] {
        PT_NULL  = 5'd0,
        PT_READ  = 5'd1,
        PT_WRITE = 5'd2,
        PT_AREAD = 5'd3,
        PT_ACK   = 5'd4,
        PT_AACK  = 5'd5,
        PT_ERR   = 5'd6,
        PT_VPA   = 5'd7,
        PT_RETRY = 5'd8
    } packet_type_t;

    typedef struct packed {
        logic [5:0]   did;
        logic [5:0]   sid;
        logic [5:0]   age;
        logic         ack;
        packet_type_t typ;
        logic [7:0]   asid;
        logic [2:0]   fc;
        logic [3:0]   sel;
        logic         mmus;
        logic         ios;
        logic         iops;
        logic [31:0]  adr;
        logic [31:0]  dat;
    } packet_t;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBus  = 1'b1
    } bus_state_t;

    function automatic logic is_request(input packet_type_t typ);
        return (typ == PT_READ) || (typ == PT_AREAD) || (typ == PT_WRITE);
    endfunction

    function automatic logic [5:0] age_inc(input logic [5:0] age);
        return (age == 6'd63) ? age : age + 6'd1;
    endfunction

endpackage

// File: rtl/rf68000_ring_req_fifo.sv
// Synchronous packet FIFO; a pop is evaluated before a push so a full FIFO
// accepts a push in the same cycle as a pop.
module rf68000_ring_req_fifo
    import nic_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  packet_t       din,
    input  logic          pop,
    output packet_t       dout,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    packet_t     mem [DEPTH];
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        do_pop;
    logic        do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (PW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PW + 1)'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rf68000_ring_gbl_responder.sv
// Global-node ring responder: pulls requests off the request ring, runs them
// on the global bus and posts ACK/AACK/ERR/VPA/RETRY packets on the response ring.
module rf68000_ring_gbl_responder
    import nic_pkg::*;
#(
    parameter logic [5:0]  NODE_ID    = GBL_NODE_ID,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        SYNC_WRITE = 1'b1,
    parameter logic [5:0]  RETRY_AGE  = 6'd8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [7:0]  m_asid_o,
    output logic [2:0]  m_fc_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_mmus_o,
    output logic        m_ios_o,
    output logic        m_iops_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic        m_vpa_i,
    input  logic [31:0] m_dat_i,
    output logic        busy_o
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    bus_state_t   state;
    packet_t      fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic [PW:0]  fifo_count;
    logic         fifo_push;
    logic         fifo_pop;

    logic         accept;
    logic         bounce;
    logic         term;
    logic [11:0]  tmo;
    logic [11:0]  tmo_inc;

    packet_type_t req_typ;
    logic [5:0]   req_sid;
    logic [31:0]  req_adr;
    logic [7:0]   req_asid;
    logic         req_mmus;
    logic         req_ios;
    logic         req_iops;

    packet_t      rsp_slot;
    logic         rsp_valid;
    packet_t      retry_slot;
    logic         retry_valid;
    packet_t      rsp_pkt;
    packet_t      retry_pkt;
    packet_type_t rsp_typ;

    logic         unused_fields;
    assign unused_fields = ^{fifo_dout.did, fifo_dout.age, fifo_dout.ack, fifo_count};

    assign accept   = (packet_i.did == NODE_ID) && (packet_i.did != BCAST_ID)
                      && is_request(packet_i.typ);
    assign fifo_pop = (state == StIdle) && !fifo_empty && !rsp_valid;
    // A full FIFO still takes a request when the head leaves on the same edge.
    assign fifo_push = accept && (!fifo_full || fifo_pop);
    assign bounce    = accept && !fifo_push && (packet_i.age >= RETRY_AGE) && !retry_valid;
    assign tmo_inc   = tmo + 12'd1;
    assign term      = m_ack_i || m_err_i || m_vpa_i || tmo_inc[11];

    rf68000_ring_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (fifo_push),
        .din   (packet_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        if (m_ack_i) begin
            rsp_typ = (req_typ == PT_AREAD) ? PT_AACK : PT_ACK;
        end else if (m_err_i) begin
            rsp_typ = PT_ERR;
        end else if (m_vpa_i) begin
            rsp_typ = PT_VPA;
        end else begin
            rsp_typ = PT_ERR;
        end

        rsp_pkt      = '0;
        rsp_pkt.typ  = rsp_typ;
        rsp_pkt.sid  = NODE_ID;
        rsp_pkt.did  = req_sid;
        rsp_pkt.adr  = req_adr;
        rsp_pkt.dat  = (req_typ == PT_WRITE) ? 32'd0 : m_dat_i;
        rsp_pkt.asid = req_asid;
        rsp_pkt.mmus = req_mmus;
        rsp_pkt.ios  = req_ios;
        rsp_pkt.iops = req_iops;
        rsp_pkt.ack  = TRUE;

        retry_pkt     = '0;
        retry_pkt.typ = PT_RETRY;
        retry_pkt.sid = NODE_ID;
        retry_pkt.did = packet_i.sid;
        retry_pkt.adr = packet_i.adr;
        retry_pkt.ack = TRUE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= StIdle;
            packet_o    <= '0;
            rpacket_o   <= '0;
            m_cyc_o     <= FALSE;
            m_stb_o     <= FALSE;
            m_we_o      <= FALSE;
            m_sel_o     <= '0;
            m_asid_o    <= '0;
            m_fc_o      <= '0;
            m_adr_o     <= '0;
            m_dat_o     <= '0;
            m_mmus_o    <= FALSE;
            m_ios_o     <= FALSE;
            m_iops_o    <= FALSE;
            busy_o      <= FALSE;
            tmo         <= '0;
            req_typ     <= PT_NULL;
            req_sid     <= '0;
            req_adr     <= '0;
            req_asid    <= '0;
            req_mmus    <= FALSE;
            req_ios     <= FALSE;
            req_iops    <= FALSE;
            rsp_slot    <= '0;
            rsp_valid   <= FALSE;
            retry_slot  <= '0;
            retry_valid <= FALSE;
        end else begin
            packet_o <= packet_i;
            if (fifo_push || bounce) begin
                packet_o.did <= EMPTY_ID;
            end else if (accept) begin
                packet_o.age <= age_inc(packet_i.age);
            end
            if (bounce) begin
                retry_slot  <= retry_pkt;
                retry_valid <= TRUE;
            end

            // One insertion per cycle into an empty ring slot; bus response first.
            rpacket_o <= rpacket_i;
            if (rpacket_i.did == EMPTY_ID) begin
                if (rsp_valid) begin
                    rpacket_o <= rsp_slot;
                    rsp_valid <= FALSE;
                end else if (retry_valid) begin
                    rpacket_o   <= retry_slot;
                    retry_valid <= FALSE;
                end
            end

            if (m_cyc_o && !term) begin
                tmo <= tmo_inc;
            end else begin
                tmo <= '0;
            end

            busy_o <= !fifo_empty || (state != StIdle);

            case (state)
                StIdle: begin
                    if (fifo_pop) begin
                        req_typ  <= fifo_dout.typ;
                        req_sid  <= fifo_dout.sid;
                        req_adr  <= fifo_dout.adr;
                        req_asid <= fifo_dout.asid;
                        req_mmus <= fifo_dout.mmus;
                        req_ios  <= fifo_dout.ios;
                        req_iops <= fifo_dout.iops;
                        m_cyc_o  <= TRUE;
                        m_stb_o  <= TRUE;
                        m_we_o   <= (fifo_dout.typ == PT_WRITE);
                        m_sel_o  <= fifo_dout.sel;
                        m_asid_o <= fifo_dout.asid;
                        m_fc_o   <= fifo_dout.fc;
                        m_adr_o  <= fifo_dout.adr;
                        m_dat_o  <= fifo_dout.dat;
                        m_mmus_o <= fifo_dout.mmus;
                        m_ios_o  <= fifo_dout.ios;
                        m_iops_o <= fifo_dout.iops;
                        state    <= StBus;
                    end
                end
                StBus: begin
                    if (term) begin
                        m_cyc_o  <= FALSE;
                        m_stb_o  <= FALSE;
                        m_we_o   <= FALSE;
                        m_sel_o  <= '0;
                        m_asid_o <= '0;
                        m_fc_o   <= '0;
                        m_adr_o  <= '0;
                        m_dat_o  <= '0;
                        m_mmus_o <= FALSE;
                        m_ios_o  <= FALSE;
                        m_iops_o <= FALSE;
                        if ((req_typ != PT_WRITE) || SYNC_WRITE) begin
                            rsp_slot  <= rsp_pkt;
                            rsp_valid <= TRUE;
                        end
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_rf68000_ring_gbl_responder.sv
// Directed bench for the global ring responder: a vector table of single bus
// transactions plus hand sequences for retry, ring backpressure, timeout and reset.
module tb_rf68000_ring_gbl_responder;
    import nic_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    packet_t packet_i, rpacket_i;
    packet_t packet_o, rpacket_o, packet_o2, rpacket_o2;
    logic        m_ack_i, m_err_i, m_vpa_i;
    logic [31:0] m_dat_i;
    logic        m_cyc_o, m_stb_o, m_we_o, m_mmus_o, m_ios_o, m_iops_o, busy_o;
    logic [3:0]  m_sel_o;
    logic [7:0]  m_asid_o;
    logic [2:0]  m_fc_o;
    logic [31:0] m_adr_o, m_dat_o;
    logic        m_cyc_o2, m_stb_o2, m_we_o2, m_mmus_o2, m_ios_o2, m_iops_o2, busy_o2;
    logic [3:0]  m_sel_o2;
    logic [7:0]  m_asid_o2;
    logic [2:0]  m_fc_o2;
    logic [31:0] m_adr_o2, m_dat_o2;

    rf68000_ring_gbl_responder u_dut (
        .clk_i(clk), .rst_i(rst), .packet_i(packet_i), .packet_o(packet_o),
        .rpacket_i(rpacket_i), .rpacket_o(rpacket_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
        .m_we_o(m_we_o), .m_sel_o(m_sel_o), .m_asid_o(m_asid_o), .m_fc_o(m_fc_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_mmus_o(m_mmus_o), .m_ios_o(m_ios_o),
        .m_iops_o(m_iops_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_vpa_i(m_vpa_i),
        .m_dat_i(m_dat_i), .busy_o(busy_o)
    );

    // Posted-write variant shares every input with the main instance.
    rf68000_ring_gbl_responder #(.SYNC_WRITE(1'b0)) u_post (
        .clk_i(clk), .rst_i(rst), .packet_i(packet_i), .packet_o(packet_o2),
        .rpacket_i(rpacket_i), .rpacket_o(rpacket_o2), .m_cyc_o(m_cyc_o2), .m_stb_o(m_stb_o2),
        .m_we_o(m_we_o2), .m_sel_o(m_sel_o2), .m_asid_o(m_asid_o2), .m_fc_o(m_fc_o2),
        .m_adr_o(m_adr_o2), .m_dat_o(m_dat_o2), .m_mmus_o(m_mmus_o2), .m_ios_o(m_ios_o2),
        .m_iops_o(m_iops_o2), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_vpa_i(m_vpa_i),
        .m_dat_i(m_dat_i), .busy_o(busy_o2)
    );

    int cmp = 0;
    int errs = 0;
    int rsp_seen = 0;
    int rsp_seen2 = 0;

    always @(negedge clk) begin
        if (rpacket_o.did != 6'd0 && rpacket_o.sid == 6'd62) rsp_seen++;
        if (rpacket_o2.did != 6'd0 && rpacket_o2.sid == 6'd62) rsp_seen2++;
    end

    typedef struct {
        packet_type_t typ;
        logic [5:0]   sid;
        logic [31:0]  adr;
        logic [31:0]  wdat;
        logic [2:0]   term;     // {vpa, err, ack}
        logic [31:0]  bus_dat;
        packet_type_t exp_typ;
        logic [31:0]  exp_dat;
        int           exp_rsp2;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic packet_t mk_req(input packet_type_t typ, input logic [5:0] did,
                                       input logic [5:0] sid, input logic [5:0] age,
                                       input logic [31:0] adr, input logic [31:0] dat);
        packet_t p;
        p      = '0;
        p.did  = did;
        p.sid  = sid;
        p.age  = age;
        p.typ  = typ;
        p.adr  = adr;
        p.dat  = dat;
        p.sel  = 4'hF;
        p.fc   = 3'd6;
        p.asid = 8'h2A;
        p.mmus = 1'b1;
        return p;
    endfunction

    // Acks every bus cycle seen within a fixed window; returns how many ran.
    task automatic drain(output int n);
        n = 0;
        for (int k = 0; k < 60; k++) begin
            if (m_cyc_o) begin
                m_ack_i = 1'b1;
                tick;
                m_ack_i = 1'b0;
                n++;
            end else begin
                tick;
            end
        end
    endtask

    initial begin
        int s0, s2, n, bad;
        packet_t filler;

        vecs[0] = '{PT_READ,  6'd3,  32'h4000_1000, 32'h0, 3'b001, 32'hDEAD_BEEF, PT_ACK,  32'hDEAD_BEEF, 1};
        vecs[1] = '{PT_AREAD, 6'd5,  32'h0000_2000, 32'h0, 3'b001, 32'h1234_5678, PT_AACK, 32'h1234_5678, 1};
        vecs[2] = '{PT_WRITE, 6'd7,  32'h4000_0010, 32'hCAFE_F00D, 3'b001, 32'h5555_5555, PT_ACK, 32'h0, 0};
        vecs[3] = '{PT_READ,  6'd9,  32'h0000_0100, 32'h0, 3'b010, 32'h0, PT_ERR, 32'h0, 1};
        vecs[4] = '{PT_READ,  6'd10, 32'h00FF_0000, 32'h0, 3'b100, 32'hA5A5_A5A5, PT_VPA, 32'hA5A5_A5A5, 1};
        vecs[5] = '{PT_READ,  6'd11, 32'h0000_0040, 32'h0, 3'b011, 32'h1111_2222, PT_ACK, 32'h1111_2222, 1};
        vecs[6] = '{PT_WRITE, 6'd12, 32'h0000_0080, 32'h0BAD_CAFE, 3'b110, 32'h7777_7777, PT_ERR, 32'h0, 0};

        rst = 1'b1;
        packet_i = '0;
        rpacket_i = '0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_vpa_i = 1'b0;
        m_dat_i = '0;
        tick; tick; tick;
        check("rst_cyc", m_cyc_o, 0);
        check("rst_stb", m_stb_o, 0);
        check("rst_adr", m_adr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_packet_o", packet_o == '0, 1);
        check("rst_rpacket_o", rpacket_o == '0, 1);
        rst = 1'b0;
        tick;

        // Non-request type and broadcast both pass through untouched.
        packet_i = mk_req(PT_ACK, 6'd62, 6'd2, 6'd0, 32'h10, 32'h0);
        tick;
        check("pass_nonreq_did", packet_o.did, 62);
        check("pass_nonreq_typ", packet_o.typ, PT_ACK);
        packet_i = mk_req(PT_READ, 6'd63, 6'd2, 6'd0, 32'h20, 32'h0);
        tick;
        check("pass_bcast_did", packet_o.did, 63);
        packet_i = '0;
        tick; tick;
        check("pass_no_cyc", m_cyc_o, 0);
        check("pass_not_busy", busy_o, 0);

        for (int i = 0; i < 7; i++) begin
            packet_i = mk_req(vecs[i].typ, 6'd62, vecs[i].sid, 6'd0, vecs[i].adr, vecs[i].wdat);
            tick;
            packet_i = '0;
            check($sformatf("v%0d_removed", i), packet_o.did, 0);
            tick;
            check($sformatf("v%0d_cyc_latency", i), m_cyc_o, 1);
            check($sformatf("v%0d_cyc_post", i), m_cyc_o2, 1);
            check($sformatf("v%0d_we", i), m_we_o, vecs[i].typ == PT_WRITE);
            check($sformatf("v%0d_adr", i), m_adr_o, vecs[i].adr);
            check($sformatf("v%0d_wdat", i), m_dat_o, vecs[i].wdat);
            check($sformatf("v%0d_sel", i), m_sel_o, 4'hF);
            s0 = rsp_seen;
            s2 = rsp_seen2;
            tick; tick;
            check($sformatf("v%0d_cyc_held", i), m_cyc_o, 1);
            {m_vpa_i, m_err_i, m_ack_i} = vecs[i].term;
            m_dat_i = vecs[i].bus_dat;
            tick;
            {m_vpa_i, m_err_i, m_ack_i} = 3'b000;
            m_dat_i = '0;
            check($sformatf("v%0d_cyc_drop", i), m_cyc_o, 0);
            tick;
            check($sformatf("v%0d_rsp_typ", i), rpacket_o.typ, vecs[i].exp_typ);
            check($sformatf("v%0d_rsp_did", i), rpacket_o.did, vecs[i].sid);
            check($sformatf("v%0d_rsp_sid", i), rpacket_o.sid, 62);
            check($sformatf("v%0d_rsp_dat", i), rpacket_o.dat, vecs[i].exp_dat);
            check($sformatf("v%0d_rsp_adr", i), rpacket_o.adr, vecs[i].adr);
            check($sformatf("v%0d_rsp_asid", i), rpacket_o.asid, 8'h2A);
            check($sformatf("v%0d_rsp_ack", i), rpacket_o.ack, 1);
            tick; tick;
            check($sformatf("v%0d_rsp_count", i), rsp_seen - s0, 1);
            check($sformatf("v%0d_rsp2_count", i), rsp_seen2 - s2, vecs[i].exp_rsp2);
        end

        // Stalled slave: one request on the bus, four queued, then the FIFO is full.
        packet_i = mk_req(PT_READ, 6'd62, 6'd20, 6'd0, 32'h0000_2000, 32'h0);
        tick;
        for (int k = 0; k < 4; k++) begin
            packet_i = mk_req(PT_READ, 6'd62, 6'd21 + 6'(k), 6'd0, 32'h3000 + 32'(k), 32'h0);
            tick;
            check($sformatf("fill%0d_removed", k), packet_o.did, 0);
        end
        packet_i = mk_req(PT_READ, 6'd62, 6'd25, 6'd8, 32'h0000_2500, 32'h0);
        tick;
        check("bounce_removed", packet_o.did, 0);
        check("bounce_busy", busy_o, 1);
        packet_i = mk_req(PT_READ, 6'd62, 6'd26, 6'd0, 32'h0000_2600, 32'h0);
        tick;
        check("full_fwd_did", packet_o.did, 62);
        check("full_fwd_age", packet_o.age, 1);
        check("retry_typ", rpacket_o.typ, PT_RETRY);
        check("retry_did", rpacket_o.did, 25);
        check("retry_sid", rpacket_o.sid, 62);
        check("retry_adr", rpacket_o.adr, 32'h0000_2500);
        check("retry_age", rpacket_o.age, 0);
        packet_i = mk_req(PT_READ, 6'd62, 6'd26, 6'd1, 32'h0000_2600, 32'h0);
        tick;
        check("circ_age", packet_o.age, 2);
        packet_i = mk_req(PT_READ, 6'd62, 6'd27, 6'd8, 32'h0000_2700, 32'h0);
        tick;
        check("bounce2_removed", packet_o.did, 0);
        packet_i = mk_req(PT_READ, 6'd62, 6'd28, 6'd8, 32'h0000_2800, 32'h0);
        tick;
        packet_i = '0;
        check("slot_busy_fwd_did", packet_o.did, 62);
        check("slot_busy_fwd_age", packet_o.age, 9);
        check("retry2_did", rpacket_o.did, 27);
        check("stall_cyc", m_cyc_o, 1);
        m_ack_i = 1'b1;
        m_dat_i = 32'h0000_0020;
        tick;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        check("stall_rel_drop", m_cyc_o, 0);
        tick;
        check("stall_rsp_did", rpacket_o.did, 20);
        check("stall_rsp_typ", rpacket_o.typ, PT_ACK);
        check("slot_full_no_cyc", m_cyc_o, 0);
        // Push into a full FIFO on the same edge the head is popped.
        packet_i = mk_req(PT_READ, 6'd62, 6'd26, 6'd2, 32'h0000_2600, 32'h0);
        tick;
        packet_i = '0;
        check("push_pop_full", packet_o.did, 0);
        check("push_pop_cyc", m_cyc_o, 1);
        check("push_pop_head", m_adr_o, 32'h0000_3000);
        drain(n);
        check("stall_drain_count", n, 5);
        check("stall_drain_idle", busy_o, 0);

        // Response ring fully occupied: response waits and no new cycle starts.
        filler = mk_req(PT_ACK, 6'd1, 6'd1, 6'd0, 32'h0, 32'h0);
        rpacket_i = filler;
        packet_i = mk_req(PT_READ, 6'd62, 6'd13, 6'd0, 32'h0000_1300, 32'h0);
        tick;
        packet_i = mk_req(PT_READ, 6'd62, 6'd14, 6'd0, 32'h0000_1400, 32'h0);
        tick;
        packet_i = '0;
        check("ringfull_cyc", m_cyc_o, 1);
        m_ack_i = 1'b1;
        m_dat_i = 32'h0BAD_F00D;
        tick;
        m_ack_i = 1'b0;
        m_dat_i = '0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (m_cyc_o || rpacket_o.sid == 6'd62 || rpacket_o.did != 6'd1) bad++;
        end
        check("ringfull_held", bad, 0);
        rpacket_i = '0;
        tick;
        check("ringfull_ins_typ", rpacket_o.typ, PT_ACK);
        check("ringfull_ins_did", rpacket_o.did, 13);
        check("ringfull_ins_dat", rpacket_o.dat, 32'h0BAD_F00D);
        check("ringfull_ins_no_cyc", m_cyc_o, 0);
        tick;
        check("ringfull_next_cyc", m_cyc_o, 1);
        check("ringfull_next_adr", m_adr_o, 32'h0000_1400);
        drain(n);
        check("ringfull_drain", n, 1);

        // Slave never answers: cycle times out after 2048 cycles with PT_ERR.
        packet_i = mk_req(PT_READ, 6'd62, 6'd4, 6'd0, 32'h5000_0000, 32'h0);
        tick;
        packet_i = '0;
        tick;
        check("tmo_cyc_start", m_cyc_o, 1);
        n = 0;
        while (m_cyc_o && n < 3000) begin
            tick;
            n++;
        end
        check("tmo_len", n, 2048);
        tick;
        check("tmo_rsp_typ", rpacket_o.typ, PT_ERR);
        check("tmo_rsp_did", rpacket_o.did, 4);
        tick; tick;

        // Reset during a bus cycle with work still queued.
        packet_i = mk_req(PT_READ, 6'd62, 6'd15, 6'd0, 32'h0000_1500, 32'h0);
        tick;
        packet_i = mk_req(PT_READ, 6'd62, 6'd16, 6'd0, 32'h0000_1600, 32'h0);
        tick;
        packet_i = '0;
        check("rstbus_cyc_before", m_cyc_o, 1);
        rst = 1'b1;
        tick;
        check("rstbus_cyc", m_cyc_o, 0);
        check("rstbus_busy", busy_o, 0);
        rst = 1'b0;
        s0 = rsp_seen;
        s2 = rsp_seen2;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (m_cyc_o || busy_o) bad++;
        end
        check("rstbus_flushed", bad, 0);
        check("rstbus_no_rsp", rsp_seen - s0, 0);
        check("rstbus_no_rsp2", rsp_seen2 - s2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
